// File: rtl/cmp_flags_seq_if.sv
// cmp_flags_seq_if: start/ready/done handshake, operands and result flags for cmp_flags_seq.
interface cmp_flags_seq_if #(parameter int WIDTH = 32);
  logic start;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic signed_mode;
  logic ready;
  logic done;
  logic isNotEqual;
  logic isLessThan;
  modport master (output start, data_operandA, data_operandB, signed_mode,
                  input ready, done, isNotEqual, isLessThan);
  modport slave (input start, data_operandA, data_operandB, signed_mode,
                 output ready, done, isNotEqual, isLessThan);
endinterface

// File: rtl/cmp_flags_seq.sv
// cmp_flags_seq: multi-cycle MSB-chunk-first comparator producing registered ne/lt flags.
// Optional CMP_EARLY_EXIT_EN finishes at the first mismatching chunk.
module cmp_flags_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic clock,
  input logic reset,
  cmp_flags_seq_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic sgn_r, ne_acc, lt_acc, ne_nx, lt_nx, fin, diff;
  logic [CHUNK-1:0] ca, cb;
  always_comb begin
    ca = CHUNK'(a_r >> (CHUNK * idx));
    cb = CHUNK'(b_r >> (CHUNK * idx));
    // Flipping the sign bit of the top chunk turns a signed compare into an unsigned one
    ca[CHUNK-1] = ca[CHUNK-1] ^ (sgn_r && idx == IW'(N - 1));
    cb[CHUNK-1] = cb[CHUNK-1] ^ (sgn_r && idx == IW'(N - 1));
    diff = ca != cb;
    ne_nx = ne_acc | diff;
    lt_nx = ne_acc ? lt_acc : (ca < cb);
`ifdef CMP_EARLY_EXIT_EN
    fin = idx == '0 || diff;
`else
    fin = idx == '0;
`endif
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) :
              state == RUN  ? (fin ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      a_r <= '0;
      b_r <= '0;
      sgn_r <= 1'b0;
      ne_acc <= 1'b0;
      lt_acc <= 1'b0;
      bus.ready <= 1'b1;
      bus.done <= 1'b0;
      bus.isNotEqual <= 1'b0;
      bus.isLessThan <= 1'b0;
    end else begin
      state <= state_n;
      bus.ready <= state_n == IDLE;
      bus.done <= state_n == DONE;
      if (state == IDLE && bus.start) begin
        a_r <= bus.data_operandA;
        b_r <= bus.data_operandB;
        sgn_r <= bus.signed_mode;
        idx <= IW'(N - 1);
        ne_acc <= 1'b0;
        lt_acc <= 1'b0;
      end else if (state == RUN) begin
        ne_acc <= ne_nx;
        lt_acc <= lt_nx;
        idx <= idx - IW'(1);
        if (fin) begin
          bus.isNotEqual <= ne_nx;
          bus.isLessThan <= lt_nx;
        end
      end
    end
  end
endmodule
